// File: rtl/uart_map_pkg.sv
// Shared constants and types for the UART-to-rotor character mapper.
// Classification of each received byte before it reaches the FIFO.
package uart_map_pkg;

    localparam logic [7:0] ASCII_UPPER_A = 8'h41;
    localparam logic [7:0] ASCII_LOWER_A = 8'h61;
    localparam int         ALPHA_DFLT    = 26;

    typedef enum logic [1:0] {
        CLS_NONE   = 2'd0,
        CLS_LETTER = 2'd1,
        CLS_REJECT = 2'd2
    } char_cls_e;

endpackage

// File: rtl/uart_char_mapper_if.sv
// Byte-in / index-out stream bundle between the UART receiver, the mapper
// and the rotor core. The input side has no ready: the UART cannot stall.
interface uart_char_mapper_if #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 6
);
    logic [IN_W-1:0]  in_data;
    logic             in_valid;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output out_data, out_valid
    );
endinterface

// File: rtl/uart_map_fifo.sv
// Generic first-word-fall-through FIFO; the head entry is always visible on dout.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module uart_map_fifo #(
    parameter int W     = 6,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;

    logic [W-1:0]     mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [LVL_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign empty     = (count_r == {LVL_W{1'b0}});
    assign full      = (count_r == LVL_W'(DEPTH));
    assign pop_ok_s  = pop && !empty;
    assign push_ok_s = push && (!full || pop_ok_s);
    assign dout      = mem_r[rd_ptr_r];
    assign level     = count_r;

    // Storage, wrapping pointers and occupancy counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {W{1'b0}};
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {LVL_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + LVL_W'(1);
                2'b01:   count_r <= count_r - LVL_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: rtl/uart_char_mapper.sv
// Validates UART bytes as letters, maps them to alphabet indices and queues them.
// Optional lower-case folding is enabled by defining UART_MAP_CASE_FOLD_EN.
module uart_char_mapper
    import uart_map_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int OUT_W = 6,
    parameter int ALPHA = ALPHA_DFLT,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    uart_char_mapper_if.slave        bus,
    input  logic                     clr_flags,
    output logic [CNT_W-1:0]         rej_cnt,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   level
);
    localparam logic [IN_W-1:0]  UPPER_A_C = IN_W'(ASCII_UPPER_A);
    localparam logic [IN_W-1:0]  ALPHA_C   = IN_W'(ALPHA);
    localparam logic [CNT_W-1:0] CNT_MAX_C = {CNT_W{1'b1}};

    logic [IN_W-1:0]  up_off_s;
`ifdef UART_MAP_CASE_FOLD_EN
    localparam logic [IN_W-1:0] LOWER_A_C = IN_W'(ASCII_LOWER_A);
    logic [IN_W-1:0]  lo_off_s;
`endif
    char_cls_e        cls_s;
    logic [OUT_W-1:0] idx_s;
    char_cls_e        s1_cls_r;
    logic [OUT_W-1:0] s1_idx_r;
    logic [CNT_W-1:0] rej_cnt_r;
    logic             overflow_r;
    logic             push_s;
    logic             pop_s;
    logic             rej_evt_s;
    logic             ovf_evt_s;
    logic             full_s;
    logic             empty_s;

    // Bytes below 'A' wrap to large offsets, so one unsigned compare covers both bounds.
    assign up_off_s = bus.in_data - UPPER_A_C;
`ifdef UART_MAP_CASE_FOLD_EN
    assign lo_off_s = bus.in_data - LOWER_A_C;
`endif

    // Combinational classifier for the byte presented this cycle.
    always_comb begin
        cls_s = CLS_NONE;
        idx_s = {OUT_W{1'b0}};
        if (!bus.in_valid) begin
            cls_s = CLS_NONE;
        end else if (up_off_s < ALPHA_C) begin
            cls_s = CLS_LETTER;
            idx_s = OUT_W'(up_off_s);
        end
`ifdef UART_MAP_CASE_FOLD_EN
        else if (lo_off_s < ALPHA_C) begin
            cls_s = CLS_LETTER;
            idx_s = OUT_W'(lo_off_s);
        end
`endif
        else begin
            cls_s = CLS_REJECT;
        end
    end

    // Stage-1 register holding the classified byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_cls_r <= CLS_NONE;
            s1_idx_r <= {OUT_W{1'b0}};
        end else begin
            s1_cls_r <= cls_s;
            s1_idx_r <= idx_s;
        end
    end

    assign push_s    = (s1_cls_r == CLS_LETTER);
    assign rej_evt_s = (s1_cls_r == CLS_REJECT);
    assign pop_s     = bus.out_valid && bus.out_ready;
    assign ovf_evt_s = push_s && full_s && !pop_s;

    // Saturating reject counter and sticky overflow; a clear discards a coincident event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rej_cnt_r  <= {CNT_W{1'b0}};
            overflow_r <= 1'b0;
        end else if (clr_flags) begin
            rej_cnt_r  <= {CNT_W{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (rej_evt_s && (rej_cnt_r != CNT_MAX_C)) begin
                rej_cnt_r <= rej_cnt_r + CNT_W'(1);
            end
            if (ovf_evt_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    uart_map_fifo #(
        .W     (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (bus.out_ready),
        .din   (s1_idx_r),
        .dout  (bus.out_data),
        .full  (full_s),
        .empty (empty_s),
        .level (level)
    );

    assign bus.out_valid = !empty_s;
    assign rej_cnt       = rej_cnt_r;
    assign overflow      = overflow_r;
endmodule

// File: tb/tb_uart_char_mapper.sv
// Directed and random stimulus for uart_char_mapper, checked every cycle against
// a queue-based reference model of the mapper's behaviour.
module tb_uart_char_mapper;
    localparam int DEPTH = 4;
    localparam int CNT_W = 8;
    localparam int CMAX  = 255;

    logic       clk;
    logic       rst;
    logic       clr_flags;
    logic [7:0] rej_cnt;
    logic       overflow;
    logic [2:0] level;

    uart_char_mapper_if #(.IN_W(8), .OUT_W(6)) bus ();

    uart_char_mapper #(
        .IN_W(8), .OUT_W(6), .ALPHA(26), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .clr_flags (clr_flags),
        .rej_cnt   (rej_cnt),
        .overflow  (overflow),
        .level     (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state
    int q[$];
    int pend_kind;   // 0 none, 1 letter, 2 reject
    int pend_idx;
    int m_rej;
    bit m_ovf;

    function automatic int idx_of(input logic [7:0] b);
        int v = int'(b);
        if (v >= 65 && v < 65 + 26) return v - 65;
`ifdef UART_MAP_CASE_FOLD_EN
        if (v >= 97 && v < 97 + 26) return v - 97;
`endif
        return -1;
    endfunction

    task automatic model_reset();
        q.delete();
        pend_kind = 0;
        pend_idx  = 0;
        m_rej     = 0;
        m_ovf     = 1'b0;
    endtask

    task automatic model_edge(input logic v, input logic [7:0] d, input logic rdy, input logic clr);
        bit rej_e = 1'b0;
        bit ovf_e = 1'b0;
        int k;
        if (q.size() != 0 && rdy) void'(q.pop_front());
        if (pend_kind == 1) begin
            if (q.size() < DEPTH) q.push_back(pend_idx);
            else ovf_e = 1'b1;
        end else if (pend_kind == 2) begin
            rej_e = 1'b1;
        end
        if (clr) begin
            m_rej = 0;
            m_ovf = 1'b0;
        end else begin
            if (rej_e && m_rej < CMAX) m_rej = m_rej + 1;
            if (ovf_e) m_ovf = 1'b1;
        end
        if (v) begin
            k = idx_of(d);
            pend_kind = (k >= 0) ? 1 : 2;
            pend_idx  = k;
        end else begin
            pend_kind = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ":out_valid"}, 32'(bus.out_valid), 32'(q.size() != 0));
        chk({tag, ":level"}, 32'(level), 32'(q.size()));
        chk({tag, ":rej_cnt"}, 32'(rej_cnt), 32'(m_rej));
        chk({tag, ":overflow"}, 32'(overflow), 32'(m_ovf));
        if (q.size() != 0) chk({tag, ":out_data"}, 32'(bus.out_data), 32'(q[0]));
    endtask

    task automatic step(input string tag, input logic v, input logic [7:0] d,
                        input logic rdy, input logic clr);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = rdy;
        clr_flags     = clr;
        @(posedge clk);
        model_edge(v, d, rdy, clr);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [7:0] rej_bytes [5];
        logic [7:0] rb;
        rej_bytes[0] = 8'h20; rej_bytes[1] = 8'h0D; rej_bytes[2] = 8'h5B;
        rej_bytes[3] = 8'h40; rej_bytes[4] = 8'hFF;

        rst = 1'b1; clr_flags = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.out_ready = 1'b0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        chk("reset:out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset:level", 32'(level), 32'd0);
        chk("reset:rej_cnt", 32'(rej_cnt), 32'd0);
        chk("reset:overflow", 32'(overflow), 32'd0);
        chk("reset:out_data", 32'(bus.out_data), 32'd0);
        rst = 1'b0;

        // Basic mapping with latency, consumer always ready
        step("map_A", 1'b1, 8'h41, 1'b1, 1'b0);
        step("map_Z", 1'b1, 8'h5A, 1'b1, 1'b0);
        chk("lat_A:out_data", 32'(bus.out_data), 32'd0);
        step("map_M", 1'b1, 8'h4D, 1'b1, 1'b0);
        chk("lat_Z:out_data", 32'(bus.out_data), 32'd25);
        step("idle1", 1'b0, 8'h00, 1'b1, 1'b0);
        chk("lat_M:out_data", 32'(bus.out_data), 32'd12);
        step("idle2", 1'b0, 8'h00, 1'b1, 1'b0);

        // Lower-case byte, behaviour depends on folding
        step("lower_b", 1'b1, 8'h62, 1'b0, 1'b0);
        step("lower_b2", 1'b0, 8'h00, 1'b0, 1'b0);
        step("lower_b3", 1'b0, 8'h00, 1'b1, 1'b0);
        step("clr0", 1'b0, 8'h00, 1'b1, 1'b1);

        // Non-letter bytes, then saturation
        for (int i = 0; i < 5; i++) step("rej5", 1'b1, rej_bytes[i], 1'b1, 1'b0);
        step("rej5_done", 1'b0, 8'h00, 1'b1, 1'b0);
        chk("rej5:count", 32'(rej_cnt), 32'd5);
        for (int i = 0; i < 300; i++) step("rej_sat", 1'b1, 8'h20, 1'b1, 1'b0);
        step("rej_sat_done", 1'b0, 8'h00, 1'b1, 1'b0);
        chk("rej_sat:count", 32'(rej_cnt), 32'd255);
        step("clr1", 1'b0, 8'h00, 1'b1, 1'b1);
        chk("clr1:rej_cnt", 32'(rej_cnt), 32'd0);

        // Overflow: six letters into a stalled 4-deep FIFO
        for (int i = 0; i < 6; i++) step("ovf_fill", 1'b1, 8'(65 + i), 1'b0, 1'b0);
        step("ovf_settle", 1'b0, 8'h00, 1'b0, 1'b0);
        chk("ovf:level", 32'(level), 32'd4);
        chk("ovf:flag", 32'(overflow), 32'd1);
        for (int i = 0; i < 5; i++) step("ovf_drain", 1'b0, 8'h00, 1'b1, 1'b0);
        step("ovf_clr", 1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovf_clr:flag", 32'(overflow), 32'd0);

        // Full FIFO with simultaneous push and pop
        for (int i = 0; i < 4; i++) step("full_fill", 1'b1, 8'(71 + i), 1'b0, 1'b0);
        step("full_settle", 1'b0, 8'h00, 1'b0, 1'b0);
        step("full_strobe", 1'b1, 8'h4B, 1'b0, 1'b0);
        step("full_pushpop", 1'b0, 8'h00, 1'b1, 1'b0);
        chk("full_pushpop:level", 32'(level), 32'd4);
        chk("full_pushpop:overflow", 32'(overflow), 32'd0);
        for (int i = 0; i < 5; i++) step("full_drain", 1'b0, 8'h00, 1'b1, 1'b0);

        // Reset mid-operation: three queued, one in stage 1
        for (int i = 0; i < 3; i++) step("rst_fill", 1'b1, 8'(80 + i), 1'b0, 1'b0);
        step("rst_settle", 1'b0, 8'h00, 1'b0, 1'b0);
        step("rst_inflight", 1'b1, 8'h53, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_async:out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_async:level", 32'(level), 32'd0);
        model_reset();
        @(posedge clk); #1;
        check_all("rst_hold");
        #3 rst = 1'b0;
        step("post_rst_E", 1'b1, 8'h45, 1'b0, 1'b0);
        chk("post_rst_lat1:out_valid", 32'(bus.out_valid), 32'd0);
        step("post_rst_w", 1'b0, 8'h00, 1'b0, 1'b0);
        chk("post_rst_lat2:out_valid", 32'(bus.out_valid), 32'd1);
        chk("post_rst_lat2:out_data", 32'(bus.out_data), 32'd4);
        step("post_rst_pop", 1'b0, 8'h00, 1'b1, 1'b0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: rb = 8'(65 + $urandom_range(0, 25));
                5, 6:          rb = 8'(97 + $urandom_range(0, 25));
                default:       rb = 8'($urandom_range(0, 255));
            endcase
            step("rand", ($urandom_range(0, 3) != 0), rb,
                 ($urandom_range(0, 2) != 0), ($urandom_range(0, 49) == 0));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_char_mapper.md
# uart_char_mapper

Parametrised, buffered mapper between the UART receiver and the Enigma rotor datapath. It accepts raw received bytes and validates each one as a letter. Letters become alphabet indices 0..ALPHA-1; every other byte is dropped and counted. Accepted indices are queued in a small first-word-fall-through FIFO with a valid/ready output handshake, so the rotor core may stall without losing characters.

## Interface
Parameters:
- `IN_W`, default 8: received byte width.
- `OUT_W`, default 6: index width; must satisfy 2^OUT_W ≥ ALPHA.
- `ALPHA`, default 26: alphabet size; letters `'A'`..`'A'+ALPHA-1` are accepted.
- `DEPTH`, default 4: FIFO entries; power of two, at least 2.
- `CNT_W`, default 8: reject-counter width.

Ports:
- `clk` input, 1: the single clock.
- `rst` input, 1: asynchronous, active-high reset.
- `in_data` input, IN_W: byte from the UART receiver.
- `in_valid` input, 1: one-cycle strobe, one per received byte. There is no backpressure.
- `out_data` output, OUT_W: letter index at the FIFO head.
- `out_valid` output, 1: the FIFO is non-empty.
- `out_ready` input, 1: the consumer accepts `out_data` this cycle.
- `clr_flags` input, 1: synchronous pulse that clears `rej_cnt` and `overflow`.
- `rej_cnt` output, CNT_W: saturating count of non-letter bytes.
- `overflow` output, 1: sticky; a letter was lost because the FIFO was full.
- `level` output, log2(DEPTH)+1: current FIFO occupancy.

## Operation
- **Stage 1 (classify).** On `in_valid` the block registers `in_data` and a classification:
  - LETTER when the byte is in `'A'`..`'A'+ALPHA-1`; index = byte − `'A'`.
  - With folding enabled (see Configuration), `'a'`..`'a'+ALPHA-1` is also LETTER; index = byte − `'a'`.
  - Anything else is REJECT.
  - Arithmetic is done at IN_W bits, then truncated to OUT_W.
- **Stage 2 (write).** A LETTER writes its index into the FIFO. A REJECT increments `rej_cnt`, which saturates at 2^CNT_W−1 and does not wrap.
- **Read.** A pop occurs when `out_valid && out_ready`. `out_data` always shows the FIFO head. `out_data` is don't-care while `out_valid`=0; the bench does not check it then.
- **Write and read in the same cycle:**
  - If the FIFO is not full, both happen.
  - If the FIFO is full, both happen and `level` stays at DEPTH. This is not an overflow.
  - If the FIFO is empty, the write happens and the pop does not (`out_valid` was 0).
- **Full.** A LETTER write while `level`==DEPTH with no pop is dropped. `overflow` sets to 1 and stays set until `clr_flags` or `rst`.
- **`clr_flags`.** Clears `rej_cnt` to 0 and `overflow` to 0. Clear wins over a coincident reject or overflow event, and that event is lost. FIFO contents are untouched.
- **Read/write pointers.** They wrap modulo DEPTH. Occupancy comes from a separate counter.

## Timing
- Reset values: `out_valid`=0, `level`=0, `rej_cnt`=0, `overflow`=0, `out_data`=0, stage-1 valid=0, pointers=0.
- Latency: a byte sampled on `in_valid` at edge N is classified at edge N. The FIFO is written at edge N+1. `out_valid` is 1 after edge N+1, so the latency is 2 cycles.
- Throughput: one byte per cycle, sustained.
- Handshake rules:
  - `out_data` and `out_valid` are stable while `out_valid`=1 and `out_ready`=0.
  - `out_valid` never depends combinationally on `out_ready`.
- Reset mid-operation: the FIFO empties immediately and the in-flight stage-1 byte is discarded. The first `in_valid` sampled after reset deasserts is processed normally.
- `rej_cnt` updates at edge N+1 for a reject sampled at edge N.

## Configuration
- Macro: `UART_MAP_CASE_FOLD_EN`.
- **Defined:** lower-case letters map to the same indices as upper-case letters.
- **Undefined:** lower-case letters are REJECT and count in `rej_cnt`.
- Default build defines it.

## Structure
- Package `uart_map_pkg` holds:
  - ASCII constants: `ASCII_UPPER_A`=8'h41, `ASCII_LOWER_A`=8'h61.
  - The default `ALPHA`=26.
  - A classification enum {CLS_NONE, CLS_LETTER, CLS_REJECT}.
- Sub-module `uart_map_fifo`: a generic DEPTH×OUT_W first-word-fall-through FIFO with push, pop, full, empty and level. The top level holds the classifier, the counters and the flags.

## Test plan
- `in_data`=8'h41, 8'h5A, 8'h4D with `out_ready`=1 → `out_data` 0, 25, 12; each appears 2 cycles after its strobe.
- `in_data`=8'h62 → index 1 with `UART_MAP_CASE_FOLD_EN` defined. Without the macro, no output and `rej_cnt`=1.
- Bytes 8'h20, 8'h0D, 8'h5B, 8'h40, 8'hFF → no `out_valid`, `rej_cnt`=5. Then 300 rejects with CNT_W=8 → `rej_cnt` holds at 255.
- DEPTH=4, `out_ready`=0, 6 letters `'A'`..`'F'` → `level`=4 and `overflow`=1. Draining yields 0, 1, 2, 3 only. Then `clr_flags` → `overflow`=0.
- With the FIFO full, a letter arrives in the same cycle as a pop → `level` stays 4, `overflow` stays 0, and the new index reaches the tail in order.
- `rst` pulsed with 3 entries queued and a byte in stage 1 → immediately `out_valid`=0, `level`=0. The next letter after reset emerges 2 cycles after its strobe.
